draw_sprite: RTL and testbench
==============================

Name: draw_sprite

Overview:
- Parametrised successor to the full-screen background drawer.
- Blits an IMG_W x IMG_H image from an external synchronous ROM to any (x0, y0) origin on the VGA pixel grid.
- Adds a start/busy/done handshake, screen-edge clipping, colour-key transparency and a solid-fill mode.
- Sits between the game FSM and the shared VGA plot mux; one instance per sprite class (keys, notes, background).

Parameters:
- IMG_W, 32, image width in pixels (>=1)
- IMG_H, 8, image height in pixels (>=1)
- ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- COL_W, 3, colour width
- X_W, 8, screen x coordinate width
- Y_W, 7, screen y coordinate width
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request a blit; sampled only in IDLE
- x0  in  X_W  origin x, latched on accepted start
- y0  in  Y_W  origin y, latched on accepted start
- key_en  in  1  enable transparency, latched on start
- key_col  in  COL_W  transparent colour, latched on start
- fill_en  in  1  solid-fill mode, latched on start
- fill_col  in  COL_W  fill colour, latched on start
- rom_addr  out  ADDR_W  ROM address; ROM returns data one cycle later
- rom_data  in  COL_W  ROM read data
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- col_out  out  COL_W  pixel colour
- plot  out  1  write pixel this cycle
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse on completion

Behaviour:
Reset
- resetn low forces state IDLE.
- All of the following clear to 0: counters, latches, rom_addr, x_out, y_out, col_out, plot, busy, done.
- Reset applies mid-blit with no completion pulse.

FSM
- States: IDLE, READ, DRAIN, DONE.
- IDLE: when start=1, latch x0, y0, key_en, key_col, fill_en, fill_col; clear col_cnt/row_cnt; go to READ. Otherwise stay.
- READ:
  - rom_addr = row_cnt*IMG_W + col_cnt, maintained as an incrementing counter with no multiplier.
  - Each cycle col_cnt increments. At col_cnt=IMG_W-1 it wraps to 0 and row_cnt increments.
  - When the issued pixel is the last one (row_cnt=IMG_H-1, col_cnt=IMG_W-1), go to DRAIN.
- DRAIN: one cycle; emits the final pixel; go to DONE.
- DONE: done=1 and busy=0 for this cycle only; go to IDLE.
- start is ignored outside IDLE. A start held high re-triggers in IDLE on the cycle after DONE.

Pipeline
- Pixel address issued in cycle t is output in cycle t+1, with x_out/y_out/col_out registered alongside rom_data.
- x_out = x0+col, y_out = y0+row, truncated to X_W/Y_W bits.
- col_out = fill_en ? fill_col : rom_data.

Plot qualification
- plot=1 only for output cycles (READ after its first cycle, and DRAIN) where all of the following hold:
  - x0+col < SCREEN_W
  - y0+row < SCREEN_H
  - NOT (key_en AND !fill_en AND rom_data==key_col)
- Comparisons use X_W+1 / Y_W+1 bit sums, so a wrap past 2^X_W counts as clipped and never as a wrap to x=0.
- When plot=0, x_out/y_out/col_out still update; consumers must gate on plot.

Timing
- With N=IMG_W*IMG_H and start accepted at edge 0:
  - busy is high for cycles 1..N+1.
  - Pixel k (raster order) is output in cycle k+2.
  - done is high in cycle N+2.
- Total is N+2 cycles from accept to done.
- IMG_W=1 or IMG_H=1 must work: counters wrap correctly and there is no extra cycle.

Test Plan:
- IMG_W=4, IMG_H=2, ROM[i]=i%8, start with x0=10, y0=20 → 8 plots at cycles 2..9 with (x,y,col) = (10,20,0)..(13,20,3), (10,21,4)..(13,21,7); done at cycle 10 only; busy cycles 1..9.
- Same image, x0=158, y0=119 → only (158,119) and (159,119) plotted; the other 6 pixels have plot=0; done still at cycle 10.
- key_en=1, key_col=3 → pixel index 3 not plotted, the other 7 plotted; then fill_en=1, fill_col=5 with key still set → all 8 plotted with col=5.
- start pulsed again at cycles 3 and 9 during a blit → ignored; no second blit; done pulses exactly once.
- resetn low at cycle 5 for 1 cycle → outputs 0 immediately, no done; a fresh start afterwards completes a normal 8-pixel blit.
- start held high continuously → back-to-back blits, done at cycles 10 and 21, rom_addr restarting at 0 each time.

Source files
------------

// File: rtl/draw_sprite_if.sv
// draw_sprite_if: sprite blitter request, ROM and pixel-plot signal bundle.
interface draw_sprite_if #(
   parameter int ADDR_W = 8,
   parameter int COL_W  = 3,
   parameter int X_W    = 8,
   parameter int Y_W    = 7
);
   logic              start;
   logic [X_W-1:0]    x0;
   logic [Y_W-1:0]    y0;
   logic              key_en;
   logic [COL_W-1:0]  key_col;
   logic              fill_en;
   logic [COL_W-1:0]  fill_col;
   logic [ADDR_W-1:0] rom_addr;
   logic [COL_W-1:0]  rom_data;
   logic [X_W-1:0]    x_out;
   logic [Y_W-1:0]    y_out;
   logic [COL_W-1:0]  col_out;
   logic              plot;
   logic              busy;
   logic              done;
   modport slave (
      input  start, x0, y0, key_en, key_col, fill_en, fill_col, rom_data,
      output rom_addr, x_out, y_out, col_out, plot, busy, done
   );
   modport master (
      output start, x0, y0, key_en, key_col, fill_en, fill_col, rom_data,
      input  rom_addr, x_out, y_out, col_out, plot, busy, done
   );
endinterface

// File: rtl/draw_sprite.sv
// draw_sprite: blits an IMG_W x IMG_H ROM image at (x0,y0) with clipping,
// colour-key transparency and solid fill; one pixel per cycle after a 1-cycle ROM latency.
module draw_sprite #(
   parameter int IMG_W    = 32,
   parameter int IMG_H    = 8,
   parameter int ADDR_W   = 8,
   parameter int COL_W    = 3,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input logic         clk,
   input logic         resetn,
   draw_sprite_if.slave bus
);
   localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
   localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [X_W:0]  X_LIM    = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0]  Y_LIM    = (Y_W+1)'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   state_t state;

   logic [CW-1:0]    col_cnt;
   logic [RW-1:0]    row_cnt;
   logic [X_W-1:0]   x0_q;
   logic [Y_W-1:0]   y0_q;
   logic             key_en_q, fill_en_q;
   logic [COL_W-1:0] key_col_q, fill_col_q;
   logic             out_vld, in_view;
   logic [X_W:0]     x_sum;
   logic [Y_W:0]     y_sum;
   logic             col_wrap, last;

   // One extra bit so an origin near the edge clips instead of wrapping to 0.
   assign x_sum    = {1'b0, x0_q} + (X_W+1)'(col_cnt);
   assign y_sum    = {1'b0, y0_q} + (Y_W+1)'(row_cnt);
   assign col_wrap = col_cnt == COL_LAST;
   assign last     = col_wrap && row_cnt == ROW_LAST;

   // Colour and transparency depend on ROM data that only arrives in the output cycle.
   assign bus.col_out = out_vld ? (fill_en_q ? fill_col_q : bus.rom_data) : '0;
   assign bus.plot    = out_vld && in_view &&
                        !(key_en_q && !fill_en_q && bus.rom_data == key_col_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         col_cnt      <= '0;
         row_cnt      <= '0;
         x0_q         <= '0;
         y0_q         <= '0;
         key_en_q     <= 1'b0;
         key_col_q    <= '0;
         fill_en_q    <= 1'b0;
         fill_col_q   <= '0;
         out_vld      <= 1'b0;
         in_view      <= 1'b0;
         bus.rom_addr <= '0;
         bus.x_out    <= '0;
         bus.y_out    <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               x0_q         <= bus.x0;
               y0_q         <= bus.y0;
               key_en_q     <= bus.key_en;
               key_col_q    <= bus.key_col;
               fill_en_q    <= bus.fill_en;
               fill_col_q   <= bus.fill_col;
               col_cnt      <= '0;
               row_cnt      <= '0;
               bus.rom_addr <= '0;
               bus.busy     <= 1'b1;
               state        <= READ;
            end
            READ: begin
               bus.x_out    <= x_sum[X_W-1:0];
               bus.y_out    <= y_sum[Y_W-1:0];
               in_view      <= x_sum < X_LIM && y_sum < Y_LIM;
               out_vld      <= 1'b1;
               bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
               col_cnt      <= col_wrap ? '0 : col_cnt + CW'(1);
               row_cnt      <= col_wrap ? row_cnt + RW'(1) : row_cnt;
               state        <= last ? DRAIN : READ;
            end
            DRAIN: begin
               out_vld  <= 1'b0;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               state    <= DONE;
            end
            DONE: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: randomized and directed blits against a pixel-list reference model,
// checked by a scoreboard monitor on plot/done/busy/rom_addr.
module tb_draw_sprite;
   localparam int W = 4, H = 2, N = W * H;

   typedef struct {int cyc; int x; int y; int col;} pix_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic [2:0] rom [256];
   pix_t pq[$];
   int   dq[$];
   int   cyc = 0, idle_from = 0, busy_lo = 0, busy_hi = -1;
   int   total = 0, passed = 0;
   bit   mon_on = 1'b0;

   always #5 clk = ~clk;

   draw_sprite_if #(.ADDR_W(8), .COL_W(3), .X_W(8), .Y_W(7)) bus ();

   draw_sprite #(
      .IMG_W(W), .IMG_H(H), .ADDR_W(8), .COL_W(3), .X_W(8), .Y_W(7),
      .SCREEN_W(160), .SCREEN_H(120)
   ) dut (.clk(clk), .resetn(resetn), .bus(bus));

   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string n, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
   endtask

   // Reference: accepted in interval c -> pixel k shown in c+k+2, done in c+N+2.
   task automatic predict(int c);
      for (int k = 0; k < N; k++) begin
         int xs, ys, d;
         xs = int'(bus.x0) + k % W;
         ys = int'(bus.y0) + k / W;
         d  = int'(rom[k]);
         if (xs < 160 && ys < 120 && !(bus.key_en && !bus.fill_en && d == int'(bus.key_col)))
            pq.push_back('{c + k + 2, xs, ys, bus.fill_en ? int'(bus.fill_col) : d});
      end
      dq.push_back(c + N + 2);
      busy_lo   = c + 1;
      busy_hi   = c + N + 1;
      idle_from = c + N + 3;
   endtask

   always @(posedge clk) begin
      if (!resetn) idle_from = cyc + 1;
      else if (bus.start && cyc >= idle_from) predict(cyc);
   end

   always @(negedge clk) begin
      bit   eb, ed;
      pix_t p;
      if (resetn && mon_on) begin
         eb = cyc >= busy_lo && cyc <= busy_hi;
         check("busy", int'(bus.busy), int'(eb));
         if (eb && cyc < busy_hi) check("rom_addr", int'(bus.rom_addr), cyc - busy_lo);
         ed = dq.size() > 0 && dq[0] == cyc;
         if (bus.done || ed) begin
            check("done", int'(bus.done), int'(ed));
            if (ed) void'(dq.pop_front());
         end
         while (pq.size() > 0 && pq[0].cyc < cyc) begin
            p = pq.pop_front();
            check("missed_plot_cycle", cyc, p.cyc);
         end
         if (bus.plot) begin
            if (pq.size() == 0) check("extra_plot", 1, 0);
            else begin
               p = pq.pop_front();
               check("plot_cycle", cyc, p.cyc);
               check("x_out", int'(bus.x_out), p.x);
               check("y_out", int'(bus.y_out), p.y);
               check("col_out", int'(bus.col_out), p.col);
            end
         end
      end
   end

   task automatic blit(int x, int y, bit ke, int kc, bit fe, int fc);
      @(posedge clk); #1;
      bus.x0 = 8'(x); bus.y0 = 7'(y);
      bus.key_en = ke; bus.key_col = 3'(kc);
      bus.fill_en = fe; bus.fill_col = 3'(fc);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((bus.busy || dq.size() > 0) && n < 100) begin
         @(posedge clk); n++;
      end
      check("blit_timeout", int'(n < 100), 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
      check({tag, "_plot"}, int'(bus.plot), 0);
      check({tag, "_x"}, int'(bus.x_out), 0);
      check({tag, "_y"}, int'(bus.y_out), 0);
      check({tag, "_col"}, int'(bus.col_out), 0);
      check({tag, "_addr"}, int'(bus.rom_addr), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.start = 0; bus.x0 = 0; bus.y0 = 0; bus.key_en = 0; bus.key_col = 0;
      bus.fill_en = 0; bus.fill_col = 0;
      for (int i = 0; i < 256; i++) rom[i] = 3'(i % 8);
      #1 check_zero("reset");
      @(posedge clk); #1 resetn = 1'b1; mon_on = 1'b1;
      repeat (2) @(posedge clk);

      blit(10, 20, 0, 0, 0, 0); wait_done();
      blit(158, 119, 0, 0, 0, 0); wait_done();
      blit(30, 40, 1, 3, 0, 0); wait_done();
      blit(30, 40, 1, 3, 1, 5); wait_done();

      // Stray start pulses at spec cycles 3 and 9 must be ignored.
      blit(50, 60, 0, 0, 0, 0);
      repeat (2) @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (5) @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done();

      blit(10, 20, 0, 0, 0, 0);
      repeat (4) @(posedge clk); #1;
      resetn = 1'b0;
      pq.delete(); dq.delete(); busy_hi = -1;
      #1 check_zero("midreset");
      @(posedge clk); #1 resetn = 1'b1;
      repeat (2) @(posedge clk);
      blit(12, 22, 0, 0, 0, 0); wait_done();

      @(posedge clk); #1;
      bus.x0 = 8'd10; bus.y0 = 7'd20; bus.key_en = 0; bus.fill_en = 0;
      bus.start = 1'b1;
      repeat (25) @(posedge clk); #1 bus.start = 1'b0;
      wait_done();

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < N; i++) rom[i] = 3'($urandom_range(0, 7));
         blit($urandom_range(0, 3) == 0 ? $urandom_range(150, 255) : $urandom_range(0, 159),
              $urandom_range(0, 3) == 0 ? $urandom_range(110, 127) : $urandom_range(0, 119),
              1'($urandom_range(0, 1)), $urandom_range(0, 7),
              1'($urandom_range(0, 3) == 0), $urandom_range(0, 7));
         wait_done();
      end

      check("pending_plots", pq.size(), 0);
      check("pending_done", dq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
